lamp_ramp_controller: RTL and testbench

- Parametrised successor to the lamp-state decoder: drives NUM_LAMPS lamp outputs as a thermometer code of a lit-lamp count.
- The count moves toward a requested target one lamp per STEP_CYCLES clocks (soft ramp), or jumps immediately in instant mode.
- Sits between the house control logic, which issues target requests, and the lamp drivers.
- Supports an emergency force-off and reports busy/done status back to the controller.

---
 rtl/lamp_pkg.sv | 18 +
 rtl/lamp_thermo_encoder.sv | 18 +
 rtl/lamp_ramp_controller.sv | 118 +++++++++++
 tb/tb_lamp_ramp_controller.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lamp_pkg.sv
// Shared types and helpers for the lamp ramp controller.
package lamp_pkg;

    localparam int unsigned LAMP_NUM_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } lamp_state_e;

    // Limit a requested lamp count to the number of physical lamps.
    function automatic int unsigned clamp_count(input int unsigned val,
                                                input int unsigned max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/lamp_thermo_encoder.sv
// Combinational count to thermometer-code encoder: bit i set iff i < count.
module lamp_thermo_encoder #(
    parameter int unsigned NUM_LAMPS = 16,
    parameter int unsigned CNT_W     = $clog2(NUM_LAMPS + 1)
) (
    input  logic [CNT_W-1:0]     count,
    output logic [NUM_LAMPS-1:0] thermo
);

    // One comparator per lamp position.
    always_comb begin
        thermo = '0;
        for (int unsigned i = 0; i < NUM_LAMPS; i++) begin
            thermo[i] = (32'(count) > i);
        end
    end

endmodule

// File: rtl/lamp_ramp_controller.sv
// Drives a thermometer-coded lamp bank toward a requested lit count,
// either instantly or one lamp per STEP_CYCLES clocks, with force-off.
module lamp_ramp_controller
    import lamp_pkg::*;
#(
    parameter int unsigned NUM_LAMPS   = LAMP_NUM_DEFAULT,
    parameter int unsigned CNT_W       = $clog2(NUM_LAMPS + 1),
    parameter int unsigned STEP_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT_W-1:0]     target_count,
    input  logic                 target_valid,
    output logic                 target_ready,
    input  logic                 instant_mode,
    input  logic                 force_off,
    output logic [NUM_LAMPS-1:0] lights_state,
    output logic [CNT_W-1:0]     current_count,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned TMR_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    lamp_state_e          state_q, state_n;
    logic [TMR_W-1:0]     timer_q, timer_n;
    logic [CNT_W-1:0]     target_q, target_n;
    logic [CNT_W-1:0]     count_n;
    logic                 done_n;
    logic [CNT_W-1:0]     tgt_clamped;
    logic [NUM_LAMPS-1:0] lights_n;
    logic                 accept;

    assign tgt_clamped = CNT_W'(clamp_count(32'(target_count), NUM_LAMPS));
    assign accept      = target_valid & target_ready;

    lamp_thermo_encoder #(
        .NUM_LAMPS (NUM_LAMPS),
        .CNT_W     (CNT_W)
    ) u_thermo (
        .count  (count_n),
        .thermo (lights_n)
    );

    // State, timer, latched target and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            target_q      <= '0;
            current_count <= '0;
            lights_state  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            target_ready  <= 1'b1;
        end else begin
            state_q       <= state_n;
            timer_q       <= timer_n;
            target_q      <= target_n;
            current_count <= count_n;
            lights_state  <= lights_n;
            busy          <= (state_n != IDLE);
            done          <= done_n;
            target_ready  <= (state_n == IDLE) & ~force_off;
        end
    end

    // Next-state logic: force-off first, then request handling and stepping.
    always_comb begin
        state_n  = state_q;
        timer_n  = timer_q;
        target_n = target_q;
        count_n  = current_count;
        done_n   = 1'b0;

        if (force_off) begin
            state_n = IDLE;
            timer_n = '0;
            count_n = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && (tgt_clamped != current_count)) begin
                        if (instant_mode) begin
                            count_n = tgt_clamped;
                            done_n  = 1'b1;
                        end else begin
                            state_n  = (tgt_clamped > current_count) ? RAMP_UP : RAMP_DOWN;
                            timer_n  = TMR_RELOAD;
                            target_n = tgt_clamped;
                        end
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (timer_q == '0) begin
                        count_n = (state_q == RAMP_UP) ? (current_count + CNT_ONE)
                                                       : (current_count - CNT_ONE);
                        timer_n = TMR_RELOAD;
                        if (count_n == target_q) begin
                            state_n = IDLE;
                            timer_n = '0;
                            done_n  = 1'b1;
                        end
                    end else begin
                        timer_n = timer_q - TMR_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    timer_n = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lamp_ramp_controller.sv
// Self-checking bench for lamp_ramp_controller (NUM_LAMPS=16, STEP_CYCLES=4).
module tb_lamp_ramp_controller;

    localparam int unsigned N  = 16;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned S  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] target_count;
    logic          target_valid;
    logic          target_ready;
    logic          instant_mode;
    logic          force_off;
    logic [N-1:0]  lights_state;
    logic [CW-1:0] current_count;
    logic          busy;
    logic          done;

    lamp_ramp_controller #(
        .NUM_LAMPS   (N),
        .CNT_W       (CW),
        .STEP_CYCLES (S)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .target_count  (target_count),
        .target_valid  (target_valid),
        .target_ready  (target_ready),
        .instant_mode  (instant_mode),
        .force_off     (force_off),
        .lights_state  (lights_state),
        .current_count (current_count),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: ramp described by start edge, start count and direction.
    int m_count, m_tgt, m_start, m_start_count, n_edge;
    bit m_ramp, m_ready, m_done;

    typedef struct {
        logic          fo;
        logic          tv;
        logic [CW-1:0] tc;
        logic          im;
        int            cnt;
        logic [N-1:0]  lights;
        logic          bsy;
        logic          dn;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n_edge);
        end
    endtask

    function automatic logic [N-1:0] thermo(input int c);
        logic [63:0] one = 64'd1;
        return N'((one << c) - one);
    endfunction

    task automatic model_reset();
        m_count = 0; m_tgt = 0; m_start = 0; m_start_count = 0;
        m_ramp = 0; m_ready = 1; m_done = 0; n_edge = 0;
    endtask

    task automatic model_edge();
        int t, k;
        m_done = 0;
        if (force_off) begin
            m_count = 0;
            m_ramp  = 0;
        end else if (m_ramp) begin
            k = n_edge - m_start;
            if (k % S == 0) begin
                m_count = (m_tgt > m_start_count) ? m_start_count + k / S
                                                  : m_start_count - k / S;
                if (m_count == m_tgt) begin
                    m_ramp = 0;
                    m_done = 1;
                end
            end
        end else if (target_valid && m_ready) begin
            t = (int'(target_count) > N) ? N : int'(target_count);
            if (t != m_count) begin
                if (instant_mode) begin
                    m_count = t;
                    m_done  = 1;
                end else begin
                    m_ramp = 1; m_tgt = t; m_start = n_edge; m_start_count = m_count;
                end
            end
        end
        m_ready = !m_ramp && !force_off;
    endtask

    task automatic compare_model();
        chk("count",  32'(current_count), 32'(m_count));
        chk("lights", 32'(lights_state),  32'(thermo(m_count)));
        chk("busy",   32'(busy),          32'(m_ramp));
        chk("done",   32'(done),          32'(m_done));
        chk("ready",  32'(target_ready),  32'(m_ready));
    endtask

    task automatic step();
        @(posedge clk);
        n_edge++;
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic idle_in();
        target_valid = 0; target_count = '0; instant_mode = 0; force_off = 0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    task automatic request(input int tc, input logic im);
        target_valid = 1; target_count = CW'(tc); instant_mode = im;
        step();
        idle_in();
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, CW'(0),  1'b0, 0,  16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, CW'(10), 1'b1, 10, 16'h03FF, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, CW'(0),  1'b0, 10, 16'h03FF, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, CW'(20), 1'b1, 16, 16'hFFFF, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, CW'(16), 1'b1, 16, 16'hFFFF, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, CW'(16), 1'b0, 16, 16'hFFFF, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, CW'(0),  1'b0, 0,  16'h0000, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, CW'(5),  1'b1, 0,  16'h0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, CW'(0),  1'b0, 0,  16'h0000, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, CW'(7),  1'b1, 7,  16'h007F, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, CW'(2),  1'b1, 2,  16'h0003, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, CW'(0),  1'b1, 0,  16'h0000, 1'b0, 1'b1};

        do_reset();
        chk("rst_count",  32'(current_count), 32'd0);
        chk("rst_lights", 32'(lights_state),  32'h0);
        chk("rst_ready",  32'(target_ready),  32'd1);
        chk("rst_busy",   32'(busy),          32'd0);
        chk("rst_done",   32'(done),          32'd0);

        // Single-cycle vectors: instant jumps, clamping, no-change, force-off.
        for (int i = 0; i < 12; i++) begin
            force_off = tbl[i].fo; target_valid = tbl[i].tv;
            target_count = tbl[i].tc; instant_mode = tbl[i].im;
            step();
            chk($sformatf("tbl%0d_count", i),  32'(current_count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_lights", i), 32'(lights_state),  32'(tbl[i].lights));
            chk($sformatf("tbl%0d_busy", i),   32'(busy),          32'(tbl[i].bsy));
            chk($sformatf("tbl%0d_done", i),   32'(done),          32'(tbl[i].dn));
        end
        idle_in();

        // Ramp 0 -> 3 with a request attempt mid-ramp.
        do_reset();
        request(3, 1'b0);
        chk("up_busy0", 32'(busy), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            if (k == 5) begin
                target_valid = 1; target_count = CW'(15); instant_mode = 1;
            end else begin
                idle_in();
            end
            step();
            chk($sformatf("up_cnt_k%0d", k),  32'(current_count), 32'(k / 4));
            chk($sformatf("up_busy_k%0d", k), 32'(busy),          32'(k < 12));
            chk($sformatf("up_done_k%0d", k), 32'(done),          32'(k == 12));
        end
        chk("up_lights", 32'(lights_state), 32'h0007);
        idle_in();
        step();
        chk("up_done_gone", 32'(done), 32'd0);

        // Ramp 16 -> 14.
        request(16, 1'b1);
        request(14, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 4) chk("dn_lights_4", 32'(lights_state), 32'h7FFF);
            if (k == 8) begin
                chk("dn_lights_8", 32'(lights_state), 32'h3FFF);
                chk("dn_done_8",   32'(done),         32'd1);
                chk("dn_busy_8",   32'(busy),         32'd0);
            end
        end

        // Force-off mid-ramp from 5 toward 12.
        request(5, 1'b1);
        request(12, 1'b0);
        step(); step();
        force_off = 1;
        step();
        force_off = 0;
        chk("fo_count",  32'(current_count), 32'd0);
        chk("fo_lights", 32'(lights_state),  32'h0);
        chk("fo_busy",   32'(busy),          32'd0);
        chk("fo_done",   32'(done),          32'd0);
        step(); step();

        // Asynchronous reset mid-ramp.
        request(12, 1'b0);
        repeat (5) step();
        #2;
        rst_n = 0;
        #1;
        chk("arst_count",  32'(current_count), 32'd0);
        chk("arst_lights", 32'(lights_state),  32'h0);
        chk("arst_busy",   32'(busy),          32'd0);
        chk("arst_ready",  32'(target_ready),  32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            force_off    = ($urandom_range(0, 99) < 3);
            target_valid = ($urandom_range(0, 99) < 30);
            target_count = CW'($urandom_range(0, (1 << CW) - 1));
            instant_mode = $urandom_range(0, 1) == 1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
